alien_sprite_fetch: RTL

Consumer side of the alien sprite address interface. Takes the per-pixel sprite address, derivative (bank) select and valid flag produced by the alien renderer, and reads a banked sprite RAM. Applies colour-key transparency and returns a registered 12-bit RGB pixel aligned with delayed h/v counts to the VGA mixer. Also exposes a blanking-gated write port so the sprite loader can fill the RAM.

---
 rtl/alien_sprite_fetch_if.sv | 33 +++
 rtl/alien_sprite_fetch.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/alien_sprite_fetch_if.sv
// alien_sprite_fetch_if
//   Bundles the renderer read request and the sprite loader write port
//   that feed alien_sprite_fetch.
//   Read request : pixel_addr, deriv_select (bank), valid
//   Write port   : wr_valid, wr_ready, wr_bank, wr_addr, wr_data
//   master = renderer/loader side, slave = alien_sprite_fetch.
interface alien_sprite_fetch_if #(
  parameter int ADDR_W = 11,
  parameter int BANK_W = 2,
  parameter int RGB_W  = 12
);
  logic [ADDR_W-1:0] pixel_addr;
  logic [BANK_W-1:0] deriv_select;
  logic              valid;

  logic              wr_valid;
  logic              wr_ready;
  logic [BANK_W-1:0] wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [RGB_W-1:0]  wr_data;

  modport master (
    output pixel_addr, deriv_select, valid,
    output wr_valid, wr_bank, wr_addr, wr_data,
    input  wr_ready
  );

  modport slave (
    input  pixel_addr, deriv_select, valid,
    input  wr_valid, wr_bank, wr_addr, wr_data,
    output wr_ready
  );
endinterface

// File: rtl/alien_sprite_fetch.sv
// alien_sprite_fetch
//   Reads a banked sprite RAM at the address produced by the alien renderer,
//   applies colour-key transparency and returns a registered RGB pixel two
//   cycles later, together with the h/v counts delayed to match.
//   The sprite loader fills the RAM through a write port that only accepts
//   transfers during blanking.
//
//   Optional build macro: ALIEN_HIT_FLASH_EN
//     When defined, a hit pulse makes opaque sprite pixels flash white on
//     alternate pairs of frames for FLASH_FRAMES frames.
//
// Ports
//   i_clk          pixel clock
//   i_rst_n        asynchronous active-low reset
//   i_h_cnt        current horizontal pixel count
//   i_v_cnt        current vertical line count
//   i_blank        1 = outside active video (also gates loader writes)
//   i_vsync_pulse  one-cycle pulse at the start of each frame
//   i_hit          one-cycle pulse: alien was hit
//   bus            read request + loader write port (slave side)
//   o_pix_rgb      output colour, 0 when not opaque
//   o_pix_opaque   1 = mixer draws o_pix_rgb over background
//   o_h_cnt_d      h count aligned with o_pix_rgb
//   o_v_cnt_d      v count aligned with o_pix_rgb
module alien_sprite_fetch #(
  parameter int               ADDR_W       = 11,
  parameter int               BANKS        = 4,
  parameter int               RGB_W        = 12,
  parameter logic [RGB_W-1:0] KEY_COLOR    = 12'h000,
  parameter int               FLASH_FRAMES = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [9:0]           i_h_cnt,
  input  logic [9:0]           i_v_cnt,
  input  logic                 i_blank,
  input  logic                 i_vsync_pulse,
  input  logic                 i_hit,
  alien_sprite_fetch_if.slave  bus,
  output logic [RGB_W-1:0]     o_pix_rgb,
  output logic                 o_pix_opaque,
  output logic [9:0]           o_h_cnt_d,
  output logic [9:0]           o_v_cnt_d
);

  localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int IDX_W  = BANK_W + ADDR_W;
  localparam int DEPTH  = 1 << IDX_W;

  // Sprite RAM: flat index {bank, addr}
  logic [RGB_W-1:0] r_mem [DEPTH];
  logic [RGB_W-1:0] r_rd_data;

  logic [IDX_W-1:0] w_rd_idx;
  logic [IDX_W-1:0] w_wr_idx;
  logic             w_wr_fire;

  // S1 pipeline registers
  logic             r_s1_v;
  logic [9:0]       r_h_s1;
  logic [9:0]       r_v_s1;

  logic             w_opaque;
  logic             w_flash_white;
  logic [RGB_W-1:0] w_rgb;

  assign w_rd_idx = {bus.deriv_select, bus.pixel_addr};
  assign w_wr_idx = {bus.wr_bank, bus.wr_addr};

  // The loader may only write while the beam is blanked, so the RAM port is
  // never shared with an active-video read of meaning.
  assign bus.wr_ready = i_blank;
  assign w_wr_fire    = bus.wr_valid & i_blank;

  always_ff @(posedge i_clk) begin
    if (w_wr_fire) begin
      r_mem[w_wr_idx] <= bus.wr_data;
    end
  end

  // Read-before-write: a same-cycle write to the read address returns the
  // old word.
  always_ff @(posedge i_clk) begin
    r_rd_data <= r_mem[w_rd_idx];
  end

  // S0 -> S1: qualify the renderer's valid with active video and carry the
  // counts alongside the RAM access.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_v <= 1'b0;
      r_h_s1 <= '0;
      r_v_s1 <= '0;
    end else begin
      r_s1_v <= bus.valid & ~i_blank;
      r_h_s1 <= i_h_cnt;
      r_v_s1 <= i_v_cnt;
    end
  end

`ifdef ALIEN_HIT_FLASH_EN
  localparam int FT_W = $clog2(FLASH_FRAMES + 1);

  logic [2:0]      r_frame_cnt;
  logic [FT_W-1:0] r_flash_timer;

  // A hit reloads the timer even if a vsync arrives in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frame_cnt   <= '0;
      r_flash_timer <= '0;
    end else begin
      if (i_vsync_pulse) begin
        r_frame_cnt <= r_frame_cnt + 3'd1;
      end
      if (i_hit) begin
        r_flash_timer <= FT_W'(FLASH_FRAMES);
      end else if (i_vsync_pulse && (r_flash_timer != '0)) begin
        r_flash_timer <= r_flash_timer - 1'b1;
      end
    end
  end

  // Flash on frames 2,3 / 6,7 of each 8-frame cycle while the timer runs.
  assign w_flash_white = (r_flash_timer != '0) & r_frame_cnt[1];
`else
  logic w_unused_flash_inputs;

  assign w_unused_flash_inputs = i_hit & i_vsync_pulse;
  assign w_flash_white         = 1'b0;
`endif

  // Transparency is decided on the stored colour, before any flash override.
  always_comb begin
    w_opaque = r_s1_v & (r_rd_data != KEY_COLOR);
    w_rgb    = '0;
    if (w_opaque) begin
      w_rgb = w_flash_white ? {RGB_W{1'b1}} : r_rd_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pix_rgb    <= '0;
      o_pix_opaque <= 1'b0;
      o_h_cnt_d    <= '0;
      o_v_cnt_d    <= '0;
    end else begin
      o_pix_rgb    <= w_rgb;
      o_pix_opaque <= w_opaque;
      o_h_cnt_d    <= r_h_s1;
      o_v_cnt_d    <= r_v_s1;
    end
  end

endmodule
